timer_set_editor: RTL and testbench

TIMER_SET_EDITOR -- requirements
Module: timer_set_editor

---
 rtl/timer_pkg.sv | 25 ++
 rtl/bcd_wrap_step.sv | 36 +++
 rtl/timer_set_editor.sv | 198 +++++++++++++++++++
 tb/tb_timer_set_editor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared state encoding, field codes and BCD limits for the timer
//            set editor.
// Revision : 1.0
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EDIT_HOUR = 2'd1,
        ST_EDIT_MIN  = 2'd2,
        ST_EDIT_SEC  = 2'd3
    } state_t;

    localparam logic [1:0] c_FIELD_HOUR = 2'd0;
    localparam logic [1:0] c_FIELD_MIN  = 2'd1;
    localparam logic [1:0] c_FIELD_SEC  = 2'd2;

    localparam logic [7:0] c_HOUR_MAX   = 8'h23;
    localparam logic [7:0] c_MINSEC_MAX = 8'h59;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/bcd_wrap_step.sv
`default_nettype none
// ============================================================================
// Module   : bcd_wrap_step
// Brief    : Combinational +/-1 step of a packed-BCD value wrapping 0..max.
// Revision : 1.0
// ============================================================================
module bcd_wrap_step (
    input  logic [7:0] i_value,
    input  logic [7:0] i_max,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_next
);

    // inc and dec together cancel out and leave the value unchanged
    always_comb begin
        o_next = i_value;
        if (i_inc && !i_dec) begin
            if (i_value == i_max)
                o_next = 8'h00;
            else if (i_value[3:0] == 4'h9)
                o_next = {i_value[7:4] + 4'h1, 4'h0};
            else
                o_next = {i_value[7:4], i_value[3:0] + 4'h1};
        end else if (i_dec && !i_inc) begin
            if (i_value == 8'h00)
                o_next = i_max;
            else if (i_value[3:0] == 4'h0)
                o_next = {i_value[7:4] - 4'h1, 4'h9};
            else
                o_next = {i_value[7:4], i_value[3:0] - 4'h1};
        end
    end

endmodule : bcd_wrap_step
`default_nettype wire

// File: rtl/timer_set_editor.sv
`default_nettype none
// ============================================================================
// Module   : timer_set_editor
// Brief    : Button-driven HH:MM:SS editor producing a BCD load for the
//            count-down timer. Define TIMER_SET_AUTO_REPEAT_EN for auto-repeat.
// Revision : 1.0
// ============================================================================
module timer_set_editor
    import timer_pkg::*;
#(
    parameter int BLINK_HALF    = 25_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_edit,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [7:0] hour_bcd_out,
    output logic [7:0] minute_bcd_out,
    output logic [7:0] second_bcd_out,
    output logic       set_timer,
    output logic       editing,
    output logic [1:0] field_sel,
    output logic       blink
);

    localparam int c_BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_HALF - 1);

    if (BLINK_HALF < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("timer_set_editor: timing parameters must be at least 1");
    end

    state_t          r_state, w_state_next;
    logic            r_edit_q, r_next_q, r_inc_q, r_dec_q;
    logic            w_edit_ev, w_next_ev, w_inc_ev, w_dec_ev;
    logic            w_in_edit, w_inc_req, w_dec_req, w_step, w_inc, w_dec;
    logic [7:0]      r_hour, r_min, r_sec;
    logic [7:0]      w_hour_nx, w_min_nx, w_sec_nx;
    logic [c_BW-1:0] r_blink_cnt;
    logic            r_blink, r_set_timer;
    logic [1:0]      w_field_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edit_q <= 1'b0;
            r_next_q <= 1'b0;
            r_inc_q  <= 1'b0;
            r_dec_q  <= 1'b0;
        end else begin
            r_edit_q <= btn_edit;
            r_next_q <= btn_next;
            r_inc_q  <= btn_inc;
            r_dec_q  <= btn_dec;
        end
    end

    assign w_edit_ev = btn_edit & ~r_edit_q;
    assign w_next_ev = btn_next & ~r_next_q;
    assign w_inc_ev  = btn_inc  & ~r_inc_q;
    assign w_dec_ev  = btn_dec  & ~r_dec_q;
    assign w_in_edit = (r_state != ST_IDLE);

`ifdef TIMER_SET_AUTO_REPEAT_EN
    localparam int c_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RW   = (c_RMAX > 1) ? $clog2(c_RMAX) : 1;
    localparam logic [c_RW-1:0] c_DELAY_LAST  = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_PERIOD_LAST = c_RW'(REPEAT_PERIOD - 1);

    logic [c_RW-1:0] r_rpt_cnt;
    logic            r_rpt_armed;
    logic            w_rpt_hold, w_rpt_step;

    // Any fresh event (including a field change or exit) restarts the hold timing
    assign w_rpt_hold = w_in_edit & (btn_inc ^ btn_dec)
                      & ~(w_edit_ev | w_next_ev | w_inc_ev | w_dec_ev);
    assign w_rpt_step = w_rpt_hold
                      & (r_rpt_cnt == (r_rpt_armed ? c_PERIOD_LAST : c_DELAY_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else if (!w_rpt_hold) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b0;
        end else if (w_rpt_step) begin
            r_rpt_cnt   <= '0;
            r_rpt_armed <= 1'b1;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end

    assign w_inc_req = w_inc_ev | (w_rpt_step & btn_inc);
    assign w_dec_req = w_dec_ev | (w_rpt_step & btn_dec);
`else
    assign w_inc_req = w_inc_ev;
    assign w_dec_req = w_dec_ev;
`endif

    // edit and next outrank value changes; inc+dec together is a no-op
    assign w_step = w_in_edit & ~w_edit_ev & ~w_next_ev & (w_inc_req ^ w_dec_req);
    assign w_inc  = w_step & w_inc_req;
    assign w_dec  = w_step & w_dec_req;

    bcd_wrap_step u_hour_step (
        .i_value (r_hour), .i_max (c_HOUR_MAX),   .i_inc (w_inc), .i_dec (w_dec), .o_next (w_hour_nx)
    );
    bcd_wrap_step u_min_step (
        .i_value (r_min),  .i_max (c_MINSEC_MAX), .i_inc (w_inc), .i_dec (w_dec), .o_next (w_min_nx)
    );
    bcd_wrap_step u_sec_step (
        .i_value (r_sec),  .i_max (c_MINSEC_MAX), .i_inc (w_inc), .i_dec (w_dec), .o_next (w_sec_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_field_sel  = c_FIELD_HOUR;
        case (r_state)
            ST_IDLE: begin
                if (w_edit_ev) w_state_next = ST_EDIT_HOUR;
            end
            ST_EDIT_HOUR: begin
                w_field_sel = c_FIELD_HOUR;
                if (w_edit_ev)      w_state_next = ST_IDLE;
                else if (w_next_ev) w_state_next = ST_EDIT_MIN;
            end
            ST_EDIT_MIN: begin
                w_field_sel = c_FIELD_MIN;
                if (w_edit_ev)      w_state_next = ST_IDLE;
                else if (w_next_ev) w_state_next = ST_EDIT_SEC;
            end
            ST_EDIT_SEC: begin
                w_field_sel = c_FIELD_SEC;
                if (w_edit_ev)      w_state_next = ST_IDLE;
                else if (w_next_ev) w_state_next = ST_EDIT_HOUR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour      <= 8'h00;
            r_min       <= 8'h00;
            r_sec       <= 8'h00;
            r_set_timer <= 1'b0;
        end else begin
            if (w_step) begin
                case (r_state)
                    ST_EDIT_HOUR: r_hour <= w_hour_nx;
                    ST_EDIT_MIN:  r_min  <= w_min_nx;
                    ST_EDIT_SEC:  r_sec  <= w_sec_nx;
                    default:      ;
                endcase
            end
            r_set_timer <= w_in_edit & w_edit_ev & ({r_hour, r_min, r_sec} != 24'h0);
        end
    end

    // Blink restarts high whenever edit is entered or the field/value moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_state_next == ST_IDLE) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!w_in_edit || w_next_ev || w_step) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign hour_bcd_out   = r_hour;
    assign minute_bcd_out = r_min;
    assign second_bcd_out = r_sec;
    assign set_timer      = r_set_timer;
    assign editing        = w_in_edit;
    assign field_sel      = w_field_sel;
    assign blink          = r_blink;

endmodule : timer_set_editor
`default_nettype wire

// File: tb/tb_timer_set_editor.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_set_editor
// Brief    : Scoreboard bench for timer_set_editor with small timing params.
// Revision : 1.0
// ============================================================================
module tb_timer_set_editor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_edit, btn_next, btn_inc, btn_dec;
    logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
    logic       set_timer, editing, blink;
    logic [1:0] field_sel;

    always #5 clk = ~clk;

    timer_set_editor #(
        .BLINK_HALF    (4),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_edit       (btn_edit),
        .btn_next       (btn_next),
        .btn_inc        (btn_inc),
        .btn_dec        (btn_dec),
        .hour_bcd_out   (hour_bcd_out),
        .minute_bcd_out (minute_bcd_out),
        .second_bcd_out (second_bcd_out),
        .set_timer      (set_timer),
        .editing        (editing),
        .field_sel      (field_sel),
        .blink          (blink)
    );

    typedef struct {
        string      name;
        logic       chk_all;
        logic [7:0] h, m, s;
        logic       ed;
        logic [1:0] fs;
        logic       bl;
        int         pulses;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   exp_pulses = 0;
    logic mon_ok;

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic e, input logic n, input logic i, input logic d);
        @(negedge clk);
        btn_edit = e; btn_next = n; btn_inc = i; btn_dec = d;
        @(negedge clk);
        btn_edit = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic ed, input logic [1:0] fs);
        exp_t e;
        #1;
        e.name = nm; e.chk_all = 1'b1; e.h = h; e.m = m; e.s = s;
        e.ed = ed; e.fs = fs; e.bl = 1'b0; e.pulses = exp_pulses;
        exp_q.push_back(e);
    endtask

    task automatic chkb(input string nm, input logic bl);
        exp_t e;
        #1;
        e.name = nm; e.chk_all = 1'b0; e.h = 8'h00; e.m = 8'h00; e.s = 8'h00;
        e.ed = 1'b0; e.fs = 2'd0; e.bl = bl; e.pulses = 0;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (set_timer === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (editing !== 1'b0) begin
                errors++;
                $display("FAIL set_timer_with_idle: editing=%b during pulse, want 0", editing);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.chk_all)
                mon_ok = (hour_bcd_out === mon_e.h) && (minute_bcd_out === mon_e.m) &&
                         (second_bcd_out === mon_e.s) && (editing === mon_e.ed) &&
                         (field_sel === mon_e.fs) && (pulse_cnt == mon_e.pulses);
            else
                mon_ok = (blink === mon_e.bl);
            if (!mon_ok) begin
                errors++;
                if (mon_e.chk_all)
                    $display("FAIL %s: got %h:%h:%h ed=%b fs=%0d pulses=%0d, want %h:%h:%h ed=%b fs=%0d pulses=%0d",
                             mon_e.name, hour_bcd_out, minute_bcd_out, second_bcd_out, editing,
                             field_sel, pulse_cnt, mon_e.h, mon_e.m, mon_e.s, mon_e.ed,
                             mon_e.fs, mon_e.pulses);
                else
                    $display("FAIL %s: got blink=%b, want %b", mon_e.name, blink, mon_e.bl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        btn_edit = 1'b0; btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        waitn(3);
        chk("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0, 2'd0);
        chkb("reset_blink", 1'b0);
        @(negedge clk); rst_n = 1'b1;
        waitn(2);
        chk("after_reset", 8'h00, 8'h00, 8'h00, 1'b0, 2'd0);

        // basic edit sequence -> 01:03:59
        press(1, 0, 0, 0); chk("enter_edit", 8'h00, 8'h00, 8'h00, 1'b1, 2'd0);
        press(0, 0, 1, 0); chk("hour_inc", 8'h01, 8'h00, 8'h00, 1'b1, 2'd0);
        press(0, 1, 0, 0); chk("next_min", 8'h01, 8'h00, 8'h00, 1'b1, 2'd1);
        repeat (3) press(0, 0, 1, 0);
        chk("min_inc3", 8'h01, 8'h03, 8'h00, 1'b1, 2'd1);
        press(0, 1, 0, 0);
        press(0, 0, 0, 1); chk("sec_dec_wrap", 8'h01, 8'h03, 8'h59, 1'b1, 2'd2);
        press(1, 0, 0, 0); exp_pulses = 1;
        chk("confirm_010359", 8'h01, 8'h03, 8'h59, 1'b0, 2'd0);

        // hour and minute wrap
        press(1, 0, 0, 0);
        press(0, 0, 0, 1); chk("hour_dec_01", 8'h00, 8'h03, 8'h59, 1'b1, 2'd0);
        press(0, 0, 0, 1); chk("hour_dec_wrap", 8'h23, 8'h03, 8'h59, 1'b1, 2'd0);
        press(0, 0, 1, 0); chk("hour_inc_wrap", 8'h00, 8'h03, 8'h59, 1'b1, 2'd0);
        press(0, 0, 0, 1);
        press(0, 1, 0, 0);
        repeat (4) press(0, 0, 0, 1);
        chk("min_dec_wrap", 8'h23, 8'h59, 8'h59, 1'b1, 2'd1);
        press(0, 0, 1, 0); chk("min_inc_wrap", 8'h23, 8'h00, 8'h59, 1'b1, 2'd1);
        press(1, 0, 0, 0); exp_pulses = 2;
        chk("confirm_230059", 8'h23, 8'h00, 8'h59, 1'b0, 2'd0);

        // simultaneous events
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 1); chk("inc_dec_same", 8'h23, 8'h00, 8'h59, 1'b1, 2'd1);
        press(1, 1, 0, 0); exp_pulses = 3;
        chk("edit_next_same", 8'h23, 8'h00, 8'h59, 1'b0, 2'd0);

        // confirm at zero -> no pulse
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0); chk("reach_zero", 8'h00, 8'h00, 8'h00, 1'b1, 2'd2);
        press(1, 0, 0, 0); chk("confirm_zero", 8'h00, 8'h00, 8'h00, 1'b0, 2'd0);

        // blink timing
        press(1, 0, 0, 0); chkb("blink_enter", 1'b1);
        waitn(3);          chkb("blink_hold", 1'b1);
        waitn(1);          chkb("blink_toggle0", 1'b0);
        waitn(4);          chkb("blink_toggle1", 1'b1);
        waitn(4);          chkb("blink_low_again", 1'b0);
        press(0, 1, 0, 0); chkb("blink_next_forced", 1'b1);
        press(1, 0, 0, 0); chkb("blink_idle", 1'b0);
        chk("blink_exit_zero", 8'h00, 8'h00, 8'h00, 1'b0, 2'd0);

        // reset mid-edit at 05:10:20
        press(1, 0, 0, 0);
        repeat (5) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (10) press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        repeat (20) press(0, 0, 1, 0);
        chk("pre_reset", 8'h05, 8'h10, 8'h20, 1'b1, 2'd2);
        @(negedge clk); rst_n = 1'b0;
        chk("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 2'd0);
        @(negedge clk); rst_n = 1'b1;
        waitn(3);
        chk("post_reset", 8'h00, 8'h00, 8'h00, 1'b0, 2'd0);

        // held inc in EDIT_SEC for 14 cycles
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        @(negedge clk); btn_inc = 1'b1;
        waitn(14);
        btn_inc = 1'b0;
`ifdef TIMER_SET_AUTO_REPEAT_EN
        chk("hold_inc", 8'h00, 8'h00, 8'h04, 1'b1, 2'd2);
        press(1, 0, 0, 0); exp_pulses = 4;
        chk("confirm_hold", 8'h00, 8'h00, 8'h04, 1'b0, 2'd0);
`else
        chk("hold_inc", 8'h00, 8'h00, 8'h01, 1'b1, 2'd2);
        press(1, 0, 0, 0); exp_pulses = 4;
        chk("confirm_hold", 8'h00, 8'h00, 8'h01, 1'b0, 2'd0);
`endif

        waitn(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_timer_set_editor
`default_nettype wire
